// File: rtl/btn_pkg.sv
// Shared definitions for the button event logic: state encoding and default hold timings.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_HELD   = 2'd1,
    ST_REPEAT = 2'd2
  } btnState_t;

  localparam int unsigned LONG_CYCLES_DEF   = 50_000_000;
  localparam int unsigned REPEAT_CYCLES_DEF = 10_000_000;

endpackage

// File: rtl/btn_event_fsm.sv
// Single-button event generator: press/release/long/repeat pulses plus held level,
// all registered, driven by one FSM and one hold counter.
module btn_event_fsm
  import btn_pkg::*;
#(
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = 26
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btnIn,
  output logic press_o,
  output logic release_o,
  output logic long_o,
  output logic repeat_o,
  output logic held_o
);

  localparam logic [CNT_W-1:0] LONG_MAX   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_MAX = CNT_W'(REPEAT_CYCLES - 1);

  btnState_t        stateQ, stateD;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             pressQ, pressD;
  logic             releaseQ, releaseD;
  logic             longQ, longD;
  logic             repeatQ, repeatD;
  logic             heldQ, heldD;

  always_comb begin
    stateD   = stateQ;
    cntD     = cntQ;
    pressD   = 1'b0;
    releaseD = 1'b0;
    longD    = 1'b0;
    repeatD  = 1'b0;
    case (stateQ)
      ST_IDLE: begin
        if (btnIn) begin
          pressD = 1'b1;
          stateD = ST_HELD;
          cntD   = '0;
        end
      end
      ST_HELD: begin
        // Release is checked first so it wins over a coincident long threshold.
        if (!btnIn) begin
          releaseD = 1'b1;
          stateD   = ST_IDLE;
          cntD     = '0;
        end else if (cntQ == LONG_MAX) begin
          longD  = 1'b1;
          stateD = ST_REPEAT;
          cntD   = '0;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      ST_REPEAT: begin
        if (!btnIn) begin
          releaseD = 1'b1;
          stateD   = ST_IDLE;
          cntD     = '0;
        end else if (cntQ == REPEAT_MAX) begin
          repeatD = 1'b1;
          cntD    = '0;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
      default: begin
        stateD = ST_IDLE;
        cntD   = '0;
      end
    endcase
    heldD = (stateD == ST_HELD) || (stateD == ST_REPEAT);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateQ   <= ST_IDLE;
      cntQ     <= '0;
      pressQ   <= 1'b0;
      releaseQ <= 1'b0;
      longQ    <= 1'b0;
      repeatQ  <= 1'b0;
      heldQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      cntQ     <= cntD;
      pressQ   <= pressD;
      releaseQ <= releaseD;
      longQ    <= longD;
      repeatQ  <= repeatD;
      heldQ    <= heldD;
    end
  end

  assign press_o   = pressQ;
  assign release_o = releaseQ;
  assign long_o    = longQ;
  assign repeat_o  = repeatQ;
  assign held_o    = heldQ;

endmodule

// File: rtl/button_events.sv
// Bank of independent per-button event generators between the debouncers and the app FSMs.
module button_events
  import btn_pkg::*;
#(
  parameter int unsigned N_BTN         = 4,
  parameter int unsigned LONG_CYCLES   = LONG_CYCLES_DEF,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_DEF,
  parameter int unsigned CNT_W         = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btnIn,
  output logic [N_BTN-1:0] press_o,
  output logic [N_BTN-1:0] release_o,
  output logic [N_BTN-1:0] long_o,
  output logic [N_BTN-1:0] repeat_o,
  output logic [N_BTN-1:0] held_o
);

  for (genvar i = 0; i < N_BTN; i++) begin : gBtn
    btn_event_fsm #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_W        (CNT_W)
    ) uFsm (
      .clk      (clk),
      .rst_n    (rst_n),
      .btnIn    (btnIn[i]),
      .press_o  (press_o[i]),
      .release_o(release_o[i]),
      .long_o   (long_o[i]),
      .repeat_o (repeat_o[i]),
      .held_o   (held_o[i])
    );
  end

endmodule

// File: tb/tb_button_events.sv
// Directed bench for button_events with short timings (long=8, repeat=4).
module tb_button_events;

  logic       clk;
  logic       rst_n;
  logic [3:0] btnIn;
  logic [3:0] press_o, release_o, long_o, repeat_o, held_o;

  int nTotal = 0;
  int nBad   = 0;

  button_events #(
    .N_BTN        (4),
    .LONG_CYCLES  (8),
    .REPEAT_CYCLES(4),
    .CNT_W        (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .btnIn    (btnIn),
    .press_o  (press_o),
    .release_o(release_o),
    .long_o   (long_o),
    .repeat_o (repeat_o),
    .held_o   (held_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed/expected packed as {press, release, long, repeat, held}.
  task automatic checkEq(input string tag, input logic [19:0] got, input logic [19:0] exp);
    nTotal++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s: got p=%b r=%b l=%b t=%b h=%b want p=%b r=%b l=%b t=%b h=%b", tag,
               got[19:16], got[15:12], got[11:8], got[7:4], got[3:0],
               exp[19:16], exp[15:12], exp[11:8], exp[7:4], exp[3:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stepCheck(input string tag, input int e, input logic [3:0] b,
                           input logic [3:0] eP, input logic [3:0] eR, input logic [3:0] eL,
                           input logic [3:0] eT, input logic [3:0] eH);
    btnIn = b;
    tick();
    checkEq($sformatf("%s e%0d", tag, e), {press_o, release_o, long_o, repeat_o, held_o},
            {eP, eR, eL, eT, eH});
  endtask

  task automatic doReset(input string tag);
    rst_n = 1'b0;
    btnIn = 4'b0000;
    tick();
    tick();
    checkEq(tag, {press_o, release_o, long_o, repeat_o, held_o}, 20'h0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    btnIn = 4'b0000;

    // Short press: btn0 high on edges 10..12.
    doReset("reset0");
    for (int e = 0; e <= 15; e++) begin
      stepCheck("short", e, {3'b000, (e >= 10 && e < 13)},
                {3'b000, (e == 10)}, {3'b000, (e == 13)}, 4'b0000, 4'b0000,
                {3'b000, (e >= 10 && e < 13)});
    end

    // Long hold with repeat: btn1 high on edges 5..25.
    doReset("reset1");
    for (int e = 0; e <= 28; e++) begin
      stepCheck("longrep", e, {2'b00, (e >= 5 && e <= 25), 1'b0},
                {2'b00, (e == 5), 1'b0}, {2'b00, (e == 26), 1'b0},
                {2'b00, (e == 13), 1'b0}, {2'b00, (e == 17 || e == 21 || e == 25), 1'b0},
                {2'b00, (e >= 5 && e <= 25), 1'b0});
    end

    // Release exactly at the long threshold: btn2 high on edges 0..7.
    doReset("reset2");
    for (int e = 0; e <= 10; e++) begin
      stepCheck("relthr", e, {1'b0, (e <= 7), 2'b00},
                {1'b0, (e == 0), 2'b00}, {1'b0, (e == 8), 2'b00}, 4'b0000, 4'b0000,
                {1'b0, (e <= 7), 2'b00});
    end

    // Minimum pulse: btn3 high on edge 4 only.
    doReset("reset3");
    for (int e = 0; e <= 7; e++) begin
      stepCheck("minpulse", e, {(e == 4), 3'b000},
                {(e == 4), 3'b000}, {(e == 5), 3'b000}, 4'b0000, 4'b0000,
                {(e == 4), 3'b000});
    end

    // Reset mid-hold: btn0 high throughout, rst_n low on edges 10 and 11.
    doReset("reset4");
    for (int e = 0; e <= 20; e++) begin
      rst_n = !(e == 10 || e == 11);
      stepCheck("rsthold", e, 4'b0001,
                {3'b000, (e == 0 || e == 12)}, 4'b0000,
                {3'b000, (e == 8 || e == 20)}, 4'b0000,
                {3'b000, (e <= 9 || e >= 12)});
    end
    rst_n = 1'b1;

    // Concurrency: all buttons high on edges 2..10.
    doReset("reset5");
    for (int e = 0; e <= 12; e++) begin
      stepCheck("concur", e, (e >= 2 && e <= 10) ? 4'b1111 : 4'b0000,
                (e == 2) ? 4'b1111 : 4'b0000, (e == 11) ? 4'b1111 : 4'b0000,
                (e == 10) ? 4'b1111 : 4'b0000, 4'b0000,
                (e >= 2 && e <= 10) ? 4'b1111 : 4'b0000);
    end

    $display("test done: total=%0d bad=%0d", nTotal, nBad);
    $finish;
  end

endmodule
